magma_decrypt_core: RTL and testbench

- Iterative GOST R 34.12-2015 "Magma" (GOST 28147-89) 64-bit block decryption core with a 256-bit key.
- Counterpart of the Magma encryption path: it takes ciphertext blocks and returns plaintext.
- Uses valid/ready handshakes on input and output, so it sits between a ciphertext source (UART/buffer unpacker) and a plaintext sink.
- Runs UNROLL Feistel rounds per clock; one block is in flight at a time.

---
 rtl/magma_decrypt_core.sv | 151 +++++++++++++++
 tb/tb_magma_decrypt_core.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magma_decrypt_core.sv
// Iterative Magma (GOST R 34.12-2015) 64-bit block decryption core.
// One block in flight; UNROLL Feistel rounds are evaluated per clock.
module magma_decrypt_core #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_key,
    input  logic [63:0]  in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_block,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("magma_decrypt_core: UNROLL must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // param-Z S-boxes; row i substitutes nibble i (nibble 0 = bits [3:0])
    localparam logic [3:0] SBOX [8][16] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    // g(k, a) = ROTL11(S(a + k mod 2^32))
    function automatic logic [31:0] round_g(input logic [31:0] k, input logic [31:0] a);
        logic [31:0] s;
        logic [31:0] t;
        logic [3:0]  nib;
        s = a + k;
        t = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            nib = 4'(s >> (4 * n));
            t   = t | (32'(SBOX[n[2:0]][nib]) << (4 * n));
        end
        return {t[20:0], t[31:21]};
    endfunction

    // Decryption schedule: K1..K8 once, then K8..K1 three times
    function automatic logic [31:0] round_key(input logic [255:0] key, input logic [5:0] rnd);
        logic [2:0]  ki;
        logic [31:0] kw;
        ki = (rnd < 6'd8) ? rnd[2:0] : (3'd7 - rnd[2:0]);
        kw = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            if (ki == n[2:0]) kw = 32'(key >> (32 * (7 - n)));
        end
        return kw;
    endfunction

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [31:0]   a1_q, a1_d;
    logic [31:0]   a0_q, a0_d;
    logic [255:0]  key_q, key_d;
    logic [63:0]   out_block_q, out_block_d;

    logic [31:0]   r1, r0, f;
    logic [5:0]    rnd;

    // Next-state, datapath rounds and output capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a1_d        = a1_q;
        a0_d        = a0_q;
        key_d       = key_q;
        out_block_d = out_block_q;
        r1          = a1_q;
        r0          = a0_q;
        f           = '0;
        rnd         = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    key_d   = in_key;
                    a1_d    = in_block[63:32];
                    a0_d    = in_block[31:0];
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == 6'd32) begin
                    out_block_d = {a1_q, a0_q};
                    state_d     = ST_DONE;
                end else begin
                    // round 31 always ends a cycle's chain since UNROLL divides 32
                    for (int unsigned j = 0; j < UNROLL; j++) begin
                        rnd = cnt_q + 6'(j);
                        f   = round_g(round_key(key_q, rnd), r0);
                        if (rnd == 6'd31) begin
                            r1 = f ^ r1;
                        end else begin
                            f  = f ^ r1;
                            r1 = r0;
                            r0 = f;
                        end
                    end
                    a1_d  = r1;
                    a0_d  = r0;
                    cnt_d = cnt_q + 6'(UNROLL);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a1_q        <= '0;
            a0_q        <= '0;
            key_q       <= '0;
            out_block_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a1_q        <= a1_d;
            a0_q        <= a0_d;
            key_q       <= key_d;
            out_block_q <= out_block_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !RST;
    assign out_valid = (state_q == ST_DONE);
    assign out_block = out_block_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_magma_decrypt_core.sv
// Scoreboard bench for magma_decrypt_core: RFC 8891 vector, latency per
// UNROLL, backpressure, mid-run reset, edge keys and random round trips.
module tb_magma_decrypt_core;

    localparam logic [255:0] RFC_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  RFC_CT  = 64'h4ee901e5c2d8ca3d;
    localparam logic [63:0]  RFC_PT  = 64'hfedcba9876543210;

    localparam logic [3:0] TB_SBOX [8][16] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_key;
    logic [63:0]  in_block;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_block;
    logic         busy;

    logic [2:0]   x_in_valid;
    logic [2:0]   x_in_ready;
    logic [2:0]   x_out_valid;
    logic [2:0]   x_busy;
    logic [63:0]  x_out_block [3];

    logic         rand_phase;
    logic         fix_ready;
    logic         rnd_ready;

    logic [63:0]  exp_q [$];
    int           checks;
    int           errors;

    int           lat_m;
    int           lat_x [3];
    int           lat_exp [3];
    logic [63:0]  held;
    logic [63:0]  pt;
    logic [63:0]  ct;
    logic [255:0] key;

    assign out_ready = rand_phase ? rnd_ready : fix_ready;

    magma_decrypt_core #(.UNROLL(1)) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_unr
        magma_decrypt_core #(.UNROLL(2 << gi)) u_dut_x (
            .CLK       (clk),
            .RST       (rst),
            .in_valid  (x_in_valid[gi]),
            .in_ready  (x_in_ready[gi]),
            .in_key    (in_key),
            .in_block  (in_block),
            .out_valid (x_out_valid[gi]),
            .out_ready (1'b1),
            .out_block (x_out_block[gi]),
            .busy      (x_busy[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] tb_g(input logic [31:0] k, input logic [31:0] a);
        logic [31:0] s;
        logic [31:0] t;
        logic [3:0]  nib;
        s = a + k;
        t = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            nib = 4'(s >> (4 * n));
            t   = t | (32'(TB_SBOX[n[2:0]][nib]) << (4 * n));
        end
        return {t[20:0], t[31:21]};
    endfunction

    // Reference encryption: K1..K8 three times, then K8..K1; last round unswapped
    function automatic logic [63:0] magma_enc(input logic [255:0] k, input logic [63:0] blk);
        logic [31:0] a1;
        logic [31:0] a0;
        logic [31:0] t;
        logic [31:0] kk;
        int unsigned ki;
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int unsigned i = 0; i < 32; i++) begin
            ki = (i < 24) ? (i % 8) : (7 - (i % 8));
            kk = 32'(k >> (32 * (7 - ki)));
            if (i == 31) begin
                a1 = tb_g(kk, a0) ^ a1;
            end else begin
                t  = a0;
                a0 = tb_g(kk, a0) ^ a1;
                a1 = t;
            end
        end
        return {a1, a0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is compared against the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h, expected no output", out_block);
            end else begin
                check("scoreboard", out_block, exp_q.pop_front());
            end
        end
    end

    // Present a block until accepted; push the expected plaintext at acceptance
    task automatic send(input logic [255:0] k, input logic [63:0] b, input logic [63:0] e,
                        input bit push);
        bit got;
        got      = 1'b0;
        in_key   = k;
        in_block = b;
        in_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            if (push) exp_q.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready, expected acceptance of %h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_key   = ~k;
        in_block = ~b;
    endtask

    task automatic drain(input string name, input int budget);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_key     = '0;
        in_block   = '0;
        x_in_valid = '0;
        fix_ready  = 1'b0;
        rand_phase = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_block", out_block, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_x_in_ready", 64'(x_in_ready), 64'h7);
        @(posedge clk);
        #1;

        // RFC vector and latency on all UNROLL variants accepted on the same edge
        fix_ready  = 1'b1;
        x_in_valid = 3'b111;
        send(RFC_KEY, RFC_CT, RFC_PT, 1'b1);
        x_in_valid = 3'b000;
        lat_m      = 0;
        lat_x      = '{0, 0, 0};
        lat_exp    = '{17, 9, 5};
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat_m == 0) lat_m = n;
            for (int g = 0; g < 3; g++) begin
                if (x_out_valid[g] && lat_x[g] == 0) begin
                    lat_x[g] = n;
                    check($sformatf("x%0d_block", g), x_out_block[g], RFC_PT);
                end
            end
        end
        check("latency_u1", 64'(lat_m), 64'd33);
        for (int g = 0; g < 3; g++) check($sformatf("latency_x%0d", g), 64'(lat_x[g]), 64'(lat_exp[g]));
        check("x_idle_after", 64'(x_busy), 64'd0);
        drain("drain_rfc", 50);

        // Backpressure with a second block waiting
        fix_ready = 1'b0;
        send(RFC_KEY, RFC_CT, RFC_PT, 1'b1);
        for (int n = 0; n < 100 && !out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        held     = out_block;
        pt       = 64'h0123456789abcdef;
        in_key   = RFC_KEY;
        in_block = magma_enc(RFC_KEY, pt);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("bp_stable", out_block, held);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1 fix_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        check("bp_idle_busy", 64'(busy), 64'd0);
        exp_q.push_back(pt);
        @(posedge clk);
        #1;
        check("bp_accept_busy", 64'(busy), 64'd1);
        check("bp_accept_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        drain("drain_bp", 100);

        // Reset ten cycles into a run, asserted between clock edges
        send(RFC_KEY, RFC_CT, RFC_PT, 1'b0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #4 rst = 1'b0;
        @(negedge clk);
        check("after_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(RFC_KEY, RFC_CT, RFC_PT, 1'b1);
        drain("drain_after_rst", 100);

        // Edge keys: carry wrap in the adder
        send('0, magma_enc('0, '0), '0, 1'b1);
        drain("drain_zero", 100);
        send('1, magma_enc('1, '1), '1, 1'b1);
        drain("drain_ones", 100);

        // Random round trips with input gaps and random sink stalls
        rand_phase = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom};
            ct  = magma_enc(key, pt);
            send(key, ct, pt, 1'b1);
        end
        drain("drain_random", 2000);
        rand_phase = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
